// File: rtl/data_path_seq.sv
// data_path_seq: bit-indexed y/s data path with its own command controller.
// One accepted command runs to completion (single-cycle update, scan or
// rotate) and signals the end with a one-cycle done pulse.
module data_path_seq #(
    parameter  int W  = 8,
    localparam int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [W-1:0]  x,
    input  logic [SW-1:0] step,
    input  logic          target,
    output logic [W-1:0]  y,
    output logic [SW-1:0] s,
    output logic          b,
    output logic          busy,
    output logic          done,
    output logic          found
);

    localparam int CW = SW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [2:0] {
        OP_LOAD    = 3'd0,
        OP_INC     = 3'd1,
        OP_ADDS    = 3'd2,
        OP_SUBS    = 3'd3,
        OP_SCAN_UP = 3'd4,
        OP_SCAN_DN = 3'd5,
        OP_ROTL    = 3'd6,
        OP_NOP     = 3'd7
    } op_t;

    // Command fields captured at accept; the inputs are free to change afterwards.
    typedef struct packed {
        op_t           op;
        logic [W-1:0]  x;
        logic [SW-1:0] step;
        logic          target;
    } cmd_t;

    state_t        state, state_nxt;
    cmd_t          cmd, cmd_nxt;
    logic [W-1:0]  y_nxt;
    logic [SW-1:0] s_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          found_nxt, done_nxt, fin;
    logic [W-1:0]  s_ext;

    assign s_ext = {{(W-SW){1'b0}}, s};
    assign b     = y[s];
    assign busy  = (state == RUN);

    // State and datapath registers; reset wins over everything, aborting any command.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cmd   <= '0;
            y     <= '0;
            s     <= '0;
            cnt   <= '0;
            found <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cmd   <= cmd_nxt;
            y     <= y_nxt;
            s     <= s_nxt;
            cnt   <= cnt_nxt;
            found <= found_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state and datapath update: accept in IDLE, execute one step per RUN cycle.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        y_nxt     = y;
        s_nxt     = s;
        cnt_nxt   = cnt;
        found_nxt = found;
        done_nxt  = 1'b0;
        fin       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cmd_nxt.op     = op_t'(op);
                    cmd_nxt.x      = x;
                    // A zero stride would never move the scan; treat it as 1.
                    cmd_nxt.step   = (step == '0) ? SW'(1) : step;
                    cmd_nxt.target = target;
                    cnt_nxt        = '0;
                    found_nxt      = 1'b0;
                    state_nxt      = RUN;
                end
            end
            RUN: begin
                case (cmd.op)
                    OP_LOAD: begin
                        y_nxt = cmd.x;
                        s_nxt = '0;
                        fin   = 1'b1;
                    end
                    OP_INC: begin
                        y_nxt = y + W'(1);
                        fin   = 1'b1;
                    end
                    OP_ADDS: begin
                        y_nxt = y + s_ext;
                        fin   = 1'b1;
                    end
                    OP_SUBS: begin
                        y_nxt = y - s_ext;
                        fin   = 1'b1;
                    end
                    OP_SCAN_UP, OP_SCAN_DN: begin
                        if (y[s] == cmd.target) begin
                            found_nxt = 1'b1;
                            fin       = 1'b1;
                        end else begin
                            // s is SW bits and W is a power of two, so this wraps mod W.
                            s_nxt   = (cmd.op == OP_SCAN_UP) ? s + cmd.step : s - cmd.step;
                            cnt_nxt = cnt + CW'(1);
                            if (cnt == CW'(W - 1))
                                fin = 1'b1;
                        end
                    end
                    OP_ROTL: begin
                        if (s == '0) begin
                            fin = 1'b1;
                        end else begin
                            y_nxt = {y[W-2:0], y[W-1]};
                            s_nxt = s - SW'(1);
                            if (s == SW'(1))
                                fin = 1'b1;
                        end
                    end
                    OP_NOP: fin = 1'b1;
                    default: fin = 1'b1;
                endcase
                if (fin) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_path_seq.sv
// Scoreboard bench for data_path_seq: W=8 and W=16 instances. Stimulus pushes
// the expected final y/s/found and done cycle; monitors pop and compare on done.
module tb_data_path_seq;

    localparam logic [2:0] LOAD = 3'd0, INC = 3'd1, ADDS = 3'd2, SUBS = 3'd3;
    localparam logic [2:0] SUP = 3'd4, SDN = 3'd5, ROTL = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [2:0]  op;
    logic [15:0] x;
    logic [3:0]  step;
    logic        target;

    logic [7:0]  y8;
    logic [2:0]  s8;
    logic        b8, busy8, done8, found8;
    logic [15:0] y16;
    logic [3:0]  s16;
    logic        b16, busy16, done16, found16;

    always #5 clk = ~clk;

    data_path_seq #(.W(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .op(op), .x(x[7:0]), .step(step[2:0]),
        .target(target), .y(y8), .s(s8), .b(b8), .busy(busy8), .done(done8), .found(found8)
    );

    data_path_seq #(.W(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .op(op), .x(x), .step(step),
        .target(target), .y(y16), .s(s16), .b(b16), .busy(busy16), .done(done16), .found(found16)
    );

    typedef struct {
        logic [15:0] y;
        logic [3:0]  s;
        logic        found;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic pd8 = 1'b0, pd16 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the W=8 instance.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            chk("done8_busy_low", {31'd0, busy8}, 32'd0);
            chk("done8_one_cycle", {31'd0, pd8}, 32'd0);
            if (q8.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL done8_unexpected: done seen with no pending command (cycle %0d)", cyc);
            end else begin
                e8 = q8.pop_front();
                chk("y8", {24'd0, y8}, {16'd0, e8.y});
                chk("s8", {29'd0, s8}, {28'd0, e8.s});
                chk("found8", {31'd0, found8}, {31'd0, e8.found});
                chk("done8_cycle", cyc, e8.cyc);
            end
        end
        pd8 = done8;
    end

    // Monitor for the W=16 instance.
    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            chk("done16_busy_low", {31'd0, busy16}, 32'd0);
            chk("done16_one_cycle", {31'd0, pd16}, 32'd0);
            if (q16.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL done16_unexpected: done seen with no pending command (cycle %0d)", cyc);
            end else begin
                e16 = q16.pop_front();
                chk("y16", {16'd0, y16}, {16'd0, e16.y});
                chk("s16", {28'd0, s16}, {28'd0, e16.s});
                chk("found16", {31'd0, found16}, {31'd0, e16.found});
                chk("done16_cycle", cyc, e16.cyc);
            end
        end
        pd16 = done16;
    end

    // Drive one accepted command and push its expected result; returns at the
    // negedge just after the accept edge.
    task automatic issue(input bit w16, input logic [2:0] o, input logic [15:0] xv,
                         input logic [3:0] st, input logic t, input logic [15:0] ey,
                         input logic [3:0] es, input logic ef, input int lat);
        exp_t e;
        @(negedge clk);
        op = o; x = xv; step = st; target = t;
        e.y = ey; e.s = es; e.found = ef; e.cyc = cyc + 1 + lat;
        if (w16) begin q16.push_back(e); start16 = 1'b1; end
        else     begin q8.push_back(e);  start8  = 1'b1; end
        @(negedge clk);
        start8 = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic wait_idle(input bit w16);
        int n = 0;
        while ((w16 ? busy16 : busy8) !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_idle: busy did not drop within 200 cycles");
        end
    endtask

    task automatic cmd(input bit w16, input logic [2:0] o, input logic [15:0] xv,
                       input logic [3:0] st, input logic t, input logic [15:0] ey,
                       input logic [3:0] es, input logic ef, input int lat);
        issue(w16, o, xv, st, t, ey, es, ef, lat);
        wait_idle(w16);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
        op = '0; x = '0; step = '0; target = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_y8", {24'd0, y8}, 32'd0);
        chk("rst_s8", {29'd0, s8}, 32'd0);
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        chk("rst_found8", {31'd0, found8}, 32'd0);
        chk("rst_y16", {16'd0, y16}, 32'd0);
        rst = 1'b1;

        // y=0x3C, s=5 via a downward scan: bits 0,7,6 miss, bit 5 hits.
        cmd(0, LOAD, 16'h3C, 0, 0, 16'h3C, 0, 0, 1);
        cmd(0, SDN, 0, 1, 1, 16'h3C, 5, 1, 4);
        chk("b8_y5", {31'd0, b8}, 32'd1);

        // LOAD: busy only between accept and completion, done one cycle.
        issue(0, LOAD, 16'hA5, 0, 0, 16'hA5, 0, 0, 1);
        chk("load_busy", {31'd0, busy8}, 32'd1);
        @(negedge clk);
        chk("load_done", {31'd0, done8}, 32'd1);
        @(negedge clk);
        chk("load_done_low", {31'd0, done8}, 32'd0);

        // INC wrap, ADDS/SUBS wrap with s=3.
        cmd(0, LOAD, 16'hFF, 0, 0, 16'hFF, 0, 0, 1);
        cmd(0, INC, 0, 0, 0, 16'h00, 0, 0, 1);
        cmd(0, LOAD, 16'hFE, 0, 0, 16'hFE, 0, 0, 1);
        cmd(0, SUP, 0, 3, 1, 16'hFE, 3, 1, 2);
        cmd(0, ADDS, 0, 0, 0, 16'h01, 3, 0, 1);
        cmd(0, SUBS, 0, 0, 0, 16'hFE, 3, 0, 1);

        // Scan hits after 5 examinations, up and down.
        cmd(0, LOAD, 16'h10, 0, 0, 16'h10, 0, 0, 1);
        cmd(0, SUP, 0, 1, 1, 16'h10, 4, 1, 5);
        cmd(0, LOAD, 16'h10, 0, 0, 16'h10, 0, 0, 1);
        cmd(0, SDN, 0, 1, 1, 16'h10, 4, 1, 5);

        // Exhaustion with step=3 and step=0 (treated as 1).
        cmd(0, LOAD, 16'h00, 0, 0, 16'h00, 0, 0, 1);
        cmd(0, SUP, 0, 3, 1, 16'h00, 0, 0, 8);
        cmd(0, SUP, 0, 0, 1, 16'h00, 0, 0, 8);

        // ROTL from y=0x81, s=3 (s reached by a target=0 scan with step 3).
        cmd(0, LOAD, 16'h81, 0, 0, 16'h81, 0, 0, 1);
        cmd(0, SUP, 0, 3, 0, 16'h81, 3, 1, 2);
        issue(0, ROTL, 0, 0, 0, 16'h0C, 0, 0, 3);
        @(negedge clk);
        chk("rotl_y1", {24'd0, y8}, 32'h03);
        chk("rotl_s1", {29'd0, s8}, 32'd2);
        @(negedge clk);
        chk("rotl_y2", {24'd0, y8}, 32'h06);
        chk("rotl_s2", {29'd0, s8}, 32'd1);
        wait_idle(0);
        cmd(0, ROTL, 0, 0, 0, 16'h0C, 0, 0, 1);

        // start pulsed while busy is ignored.
        cmd(0, LOAD, 16'h00, 0, 0, 16'h00, 0, 0, 1);
        issue(0, SUP, 0, 1, 1, 16'h00, 0, 0, 8);
        @(negedge clk);
        op = LOAD; x = 16'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle(0);

        // start held high across done: second INC accepted in the done cycle.
        cmd(0, LOAD, 16'h55, 0, 0, 16'h55, 0, 0, 1);
        @(negedge clk);
        op = INC; x = '0; step = '0; target = 1'b0;
        e.y = 16'h56; e.s = 0; e.found = 1'b0; e.cyc = cyc + 2;
        q8.push_back(e);
        e.y = 16'h57; e.cyc = cyc + 4;
        q8.push_back(e);
        start8 = 1'b1;
        repeat (3) @(negedge clk);
        start8 = 1'b0;
        wait_idle(0);

        // Reset during the third cycle of a scan aborts with no done.
        cmd(0, LOAD, 16'h80, 0, 0, 16'h80, 0, 0, 1);
        @(negedge clk);
        op = SUP; step = 1; target = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_y8", {24'd0, y8}, 32'd0);
        chk("abort_s8", {29'd0, s8}, 32'd0);
        chk("abort_busy8", {31'd0, busy8}, 32'd0);
        chk("abort_found8", {31'd0, found8}, 32'd0);
        chk("abort_done8", {31'd0, done8}, 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // W=16 instance.
        cmd(1, LOAD, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 1);
        cmd(1, INC, 0, 0, 0, 16'h0000, 0, 0, 1);
        cmd(1, LOAD, 16'h8000, 0, 0, 16'h8000, 0, 0, 1);
        cmd(1, SUP, 0, 1, 1, 16'h8000, 15, 1, 16);
        chk("b16_y15", {31'd0, b16}, 32'd1);

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 32'd0);
        chk("q16_drained", q16.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
